// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: framing constants shared by the I2S receiver and transmitter
package i2s_rx_pkg;
  localparam int SLOTLEN = 32;
  localparam int POS_W = 6;
  localparam logic [POS_W-1:0] POS_SAT = 6'd63;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_slot_counter.sv
// i2s_slot_counter: lrclk edge detect, slot position counter and slot-length check
module i2s_slot_counter
  import i2s_rx_pkg::*;
(
  input  logic             bclk,
  input  logic             reset,
  input  logic             lrclk,
  output logic             chan,
  output logic [POS_W-1:0] pos,
  output logic             armed,
  output logic             slot_err,
  output logic             stall
);
  logic lr_q, lr_d, armed_q, armed_d, lr_edge;
  logic [POS_W-1:0] pos_q, pos_d;
  always_comb begin
    lr_d = lrclk;
    lr_edge = lrclk != lr_q;
    stall = lr_edge && armed_q && pos_q == POS_SAT;
    slot_err = lr_edge && armed_q && pos_q != POS_W'(SLOTLEN - 1);
    pos_d = lr_edge ? '0 : pos_q == POS_SAT ? pos_q : pos_q + POS_W'(1);
    // a stalled frame disarms so the following edge re-arms like a fresh start
    armed_d = lr_edge ? !stall : armed_q;
  end
  assign chan = lr_q;
  assign pos = pos_q;
  assign armed = armed_q;
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      lr_q <= CH_LEFT;
      pos_q <= POS_W'(SLOTLEN - 1);
      armed_q <= 1'b0;
    end else begin
      lr_q <= lr_d;
      pos_q <= pos_d;
      armed_q <= armed_d;
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S deserialiser delivering signed left/right samples with valid strobes
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int BITSIZE = 16
) (
  input  logic               bclk,
  input  logic               reset,
  input  logic               lrclk,
  input  logic               sdata,
  input  logic               err_clr,
  output logic [BITSIZE-1:0] sample_l,
  output logic [BITSIZE-1:0] sample_r,
  output logic               l_valid,
  output logic               r_valid,
  output logic               locked,
  output logic               sync_err
);
  logic chan, armed, slot_err, stall, cap, done;
  logic [POS_W-1:0] pos;
  logic [BITSIZE-1:0] shift_q, shift_d, word, sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic l_valid_q, l_valid_d, r_valid_q, r_valid_d, locked_q, locked_d, sync_err_q, sync_err_d;
  i2s_slot_counter u_slot (
    .bclk     (bclk),
    .reset    (reset),
    .lrclk    (lrclk),
    .chan     (chan),
    .pos      (pos),
    .armed    (armed),
    .slot_err (slot_err),
    .stall    (stall)
  );
  always_comb begin
    cap = pos >= POS_W'(1) && pos <= POS_W'(BITSIZE);
    word = {shift_q[BITSIZE-2:0], sdata};
    // the LSB is taken straight from sdata so the word lands on its own sampling edge
    done = armed && pos == POS_W'(BITSIZE);
    shift_d = cap ? word : shift_q;
    l_valid_d = done && chan == CH_LEFT;
    r_valid_d = done && chan == CH_RIGHT;
    sample_l_d = l_valid_d ? word : sample_l_q;
    sample_r_d = r_valid_d ? word : sample_r_q;
    locked_d = stall ? 1'b0 : done ? 1'b1 : locked_q;
    sync_err_d = slot_err ? 1'b1 : err_clr ? 1'b0 : sync_err_q;
  end
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      l_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      locked_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      l_valid_q <= l_valid_d;
      r_valid_q <= r_valid_d;
      locked_q <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end
  assign sample_l = sample_l_q;
  assign sample_r = sample_r_q;
  assign l_valid = l_valid_q;
  assign r_valid = r_valid_q;
  assign locked = locked_q;
  assign sync_err = sync_err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed checks of i2s_rx at BITSIZE 16 and 24 sharing one serial stream
module tb_i2s_rx;
  logic bclk, reset, lrclk, sdata, err_clr;
  logic [15:0] sl16, sr16;
  logic [23:0] sl24, sr24;
  logic l16, r16, lk16, se16, l24, r24, lk24, se24;
  int tests = 0, fails = 0;
  int vcnt, ocnt, vj, both = 0, clr_at = -1;
  logic dsel, last_lr, se0, lk0;

  i2s_rx #(.BITSIZE(16)) dut16 (
    .bclk(bclk), .reset(reset), .lrclk(lrclk), .sdata(sdata), .err_clr(err_clr),
    .sample_l(sl16), .sample_r(sr16), .l_valid(l16), .r_valid(r16),
    .locked(lk16), .sync_err(se16)
  );
  i2s_rx #(.BITSIZE(24)) dut24 (
    .bclk(bclk), .reset(reset), .lrclk(lrclk), .sdata(sdata), .err_clr(err_clr),
    .sample_l(sl24), .sample_r(sr24), .l_valid(l24), .r_valid(r24),
    .locked(lk24), .sync_err(se24)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] w16(input logic [15:0] w);
    return {2'b00, w, 14'h0};
  endfunction

  function automatic logic [31:0] cur_sample();
    return dsel ? (last_lr ? {8'h0, sr24} : {8'h0, sl24})
                : (last_lr ? {16'h0, sr16} : {16'h0, sl16});
  endfunction

  // slot cycle j = 0 is the bclk edge on which the new lrclk level is first sampled
  task automatic slot(input logic lr, input logic [31:0] bits, input int len);
    vcnt = 0; ocnt = 0; vj = -1; last_lr = lr;
    for (int j = 0; j < len; j++) begin
      @(negedge bclk);
      lrclk = lr;
      sdata = bits[31 - (j % 32)];
      err_clr = (j == clr_at);
      @(posedge bclk);
      #1;
      if (dsel ? (lr ? r24 : l24) : (lr ? r16 : l16)) begin vcnt++; vj = j; end
      if (dsel ? (lr ? l24 : r24) : (lr ? l16 : r16)) ocnt++;
      if ((l16 && r16) || (l24 && r24)) both++;
      if (j == 0) begin
        se0 = dsel ? se24 : se16;
        lk0 = dsel ? lk24 : lk16;
      end
    end
    err_clr = 1'b0;
  endtask

  task automatic check_slot(input string tag, input int exp_cnt, input logic [31:0] expv);
    chk({tag, "_cnt"}, vcnt, exp_cnt);
    chk({tag, "_other"}, ocnt, 0);
    if (exp_cnt != 0) begin
      chk({tag, "_pos"}, vj, dsel ? 25 : 17);
      chk({tag, "_data"}, cur_sample(), expv);
    end
  endtask

  initial begin
    reset = 1'b1; lrclk = 1'b0; sdata = 1'b0; err_clr = 1'b0; dsel = 1'b0;
    slot(1'b0, 32'h0, 2);
    chk("rst_sl", sl16, 0);
    chk("rst_sr", sr16, 0);
    chk("rst_lv", l16, 0);
    chk("rst_rv", r16, 0);
    chk("rst_lock", lk16, 0);
    chk("rst_err", se16, 0);
    chk("rst_sl24", sl24, 0);
    reset = 1'b0;
    // test 1: partial left slot is discarded, then full 16-bit frames
    slot(1'b0, 32'hFFFF_FFFF, 10);
    check_slot("t1_partial", 0, 0);
    slot(1'b1, w16(16'h7FFE), 32);
    check_slot("t1_r0", 1, 32'h7FFE);
    for (int f = 0; f < 2; f++) begin
      slot(1'b0, w16(16'h8001), 32);
      check_slot("t1_l", 1, 32'h8001);
      slot(1'b1, w16(16'h7FFE), 32);
      check_slot("t1_r", 1, 32'h7FFE);
    end
    chk("t1_lock", lk16, 1);
    chk("t1_err", se16, 0);
    // test 2: 24-bit words with garbage in the trailing slot bits
    dsel = 1'b1;
    for (int f = 0; f < 2; f++) begin
      slot(1'b0, {2'b11, 24'hFFFFFF, 6'b000000}, 32);
      check_slot("t2_l", 1, 32'hFFFFFF);
      slot(1'b1, {2'b11, 24'h000001, 6'b111111}, 32);
      check_slot("t2_r", 1, 32'h000001);
    end
    chk("t2_lock", lk24, 1);
    chk("t2_err", se24, 0);
    // test 3: one 30-bclk slot
    dsel = 1'b0;
    slot(1'b0, w16(16'h1234), 30);
    check_slot("t3_short", 1, 32'h1234);
    chk("t3_pre_err", se16, 0);
    slot(1'b1, w16(16'hF0F0), 32);
    chk("t3_edge_err", se0, 1);
    check_slot("t3_r", 1, 32'hF0F0);
    slot(1'b0, w16(16'h0F0F), 32);
    check_slot("t3_l", 1, 32'h0F0F);
    clr_at = 5;
    slot(1'b1, w16(16'hA5A5), 32);
    clr_at = -1;
    check_slot("t3_r2", 1, 32'hA5A5);
    chk("t3_clr", se16, 0);
    // test 4: lrclk stalled low for 80 bclk
    slot(1'b0, w16(16'h5A5A), 80);
    check_slot("t4_stall", 1, 32'h5A5A);
    slot(1'b1, w16(16'h3C3C), 32);
    chk("t4_edge_err", se0, 1);
    chk("t4_edge_lock", lk0, 0);
    check_slot("t4_rearm", 0, 0);
    chk("t4_lock_low", lk16, 0);
    chk("t4_sr_held", sr16, 16'hA5A5);
    slot(1'b0, w16(16'hC3C3), 32);
    check_slot("t4_l", 1, 32'hC3C3);
    chk("t4_relock", lk16, 1);
    // test 6: short slot drops its word; err_clr loses to a same-cycle error
    clr_at = 3;
    slot(1'b1, w16(16'h3C3C), 32);
    clr_at = -1;
    check_slot("t6_r", 1, 32'h3C3C);
    chk("t6_clr", se16, 0);
    slot(1'b0, 32'hFFFF_FFFF, 10);
    check_slot("t6_drop", 0, 0);
    chk("t6_sl_held", sl16, 16'hC3C3);
    chk("t6_pre_err", se16, 0);
    clr_at = 0;
    slot(1'b1, w16(16'h1357), 32);
    clr_at = -1;
    chk("t6_err_wins", se0, 1);
    check_slot("t6_clean", 1, 32'h1357);
    // test 5: reset at pos 10 of a right slot
    slot(1'b0, w16(16'h2468), 32);
    check_slot("t5_l", 1, 32'h2468);
    slot(1'b1, w16(16'h1111), 11);
    reset = 1'b1;
    #1;
    chk("t5_sl", sl16, 0);
    chk("t5_sr", sr16, 0);
    chk("t5_lock", lk16, 0);
    chk("t5_err", se16, 0);
    slot(1'b1, w16(16'h1111), 21);
    slot(1'b0, 32'h0, 4);
    reset = 1'b0;
    slot(1'b0, 32'hFFFF_FFFF, 12);
    check_slot("t5_partial", 0, 0);
    slot(1'b1, w16(16'h0FF0), 32);
    check_slot("t5_first", 1, 32'h0FF0);
    chk("t5_relock", lk16, 1);
    chk("t5_noerr", se16, 0);
    chk("both_valid", both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
